mlc_program_verify_ctrl: RTL and testbench

- Sequences iterative program-and-verify writes into the 4-bit MLC ReRAM crossbar weight array.
- Accepts one cell-write request at a time over a valid/ready handshake.
- Reads the cell back, compares the level against the target, then issues incremental SET/RESET pulses until the level is within tolerance or the pulse budget runs out.
- Reports a status and the pulse count to the host, and sits between the weight-loader and the crossbar programming port.

---
 rtl/mlc_program_verify_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_mlc_program_verify_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlc_program_verify_ctrl.sv
// rtl/mlc_program_verify_ctrl.sv - iterative program-and-verify sequencer for one MLC ReRAM cell
//
// Takes one cell-write request at a time. It reads the cell back and compares the level
// with the target. It then issues SET/RESET pulses, re-reading after each one, until the
// level is within tolerance or the pulse budget is spent. Finally it reports a status.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_row/req_col/req_weight      target cell address and level
//   cell_row/cell_col               latched address driven to the crossbar while busy
//   read_en                         one-cycle read-back strobe
//   read_valid/read_level           read-back response
//   pulse_en/pulse_set              programming pulse (set=1 raises the level)
//   rsp_valid/rsp_ready             response handshake
//   rsp_status/rsp_pulses           00 OK, 01 FAIL, 10 TIMEOUT, 11 ADDR_ERR; pulses issued
//   busy                            high whenever not idle
module mlc_program_verify_ctrl #(
    parameter int ROWS             = 32,
    parameter int COLS             = 10,
    parameter int WEIGHT_PRECISION = 4,
    parameter int MAX_PULSES       = 8,
    parameter int TOLERANCE        = 0,
    parameter int PULSE_CYCLES     = 2,
    parameter int READ_TIMEOUT     = 16,
    localparam int CNT_W           = $clog2(MAX_PULSES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [4:0]                  req_row,
    input  logic [3:0]                  req_col,
    input  logic [WEIGHT_PRECISION-1:0] req_weight,
    output logic [4:0]                  cell_row,
    output logic [3:0]                  cell_col,
    output logic                        read_en,
    input  logic                        read_valid,
    input  logic [WEIGHT_PRECISION-1:0] read_level,
    output logic                        pulse_en,
    output logic                        pulse_set,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [1:0]                  rsp_status,
    output logic [CNT_W-1:0]            rsp_pulses,
    output logic                        busy
);

    localparam int TMO_W = $clog2(READ_TIMEOUT + 1);
    localparam int PCY_W = $clog2(PULSE_CYCLES + 1);

    localparam logic [TMO_W-1:0]          TMO_LAST = TMO_W'(READ_TIMEOUT - 1);
    localparam logic [PCY_W-1:0]          PCY_LAST = PCY_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]          CNT_MAX  = CNT_W'(MAX_PULSES);
    localparam logic [WEIGHT_PRECISION:0] TOL      = (WEIGHT_PRECISION + 1)'(TOLERANCE);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_FAIL     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_ADDR_ERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_READ,
        S_COMPARE,
        S_PULSE,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [4:0]                  row_q;
    logic [3:0]                  col_q;
    logic [WEIGHT_PRECISION-1:0] target_q;
    logic [WEIGHT_PRECISION-1:0] level_q;
    logic [CNT_W-1:0]            pulse_cnt;
    logic [TMO_W-1:0]            tmo_cnt;
    logic [PCY_W-1:0]            pcy_cnt;
    logic [1:0]                  status_q;
    logic                        set_q;

    logic                        addr_ok;
    logic [WEIGHT_PRECISION:0]   diff;
    logic                        in_tol;
    logic                        budget_spent;

    assign addr_ok = (32'(req_row) < ROWS) && (32'(req_col) < COLS);

    // One extra bit so the absolute difference never wraps.
    assign diff = (level_q >= target_q) ? ({1'b0, level_q} - {1'b0, target_q})
                                        : ({1'b0, target_q} - {1'b0, level_q});
    assign in_tol       = (diff <= TOL);
    assign budget_spent = (pulse_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        read_en    = 1'b0;
        pulse_en   = 1'b0;
        pulse_set  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_status = 2'b00;
        rsp_pulses = '0;
        cell_row   = row_q;
        cell_col   = col_q;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                cell_row  = '0;
                cell_col  = '0;
                if (req_valid) begin
                    state_next = addr_ok ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                read_en    = 1'b1;
                state_next = S_WAIT_READ;
            end
            S_WAIT_READ: begin
                // A response arriving on the last allowed cycle still wins over the timeout.
                if (read_valid) begin
                    state_next = S_COMPARE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_COMPARE: begin
                if (in_tol || budget_spent) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_PULSE;
                end
            end
            S_PULSE: begin
                pulse_en  = 1'b1;
                pulse_set = set_q;
                if (pcy_cnt == PCY_LAST) begin
                    state_next = S_READ;
                end
            end
            S_DONE: begin
                rsp_valid  = 1'b1;
                rsp_status = status_q;
                rsp_pulses = pulse_cnt;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            col_q     <= '0;
            target_q  <= '0;
            level_q   <= '0;
            pulse_cnt <= '0;
            tmo_cnt   <= '0;
            pcy_cnt   <= '0;
            status_q  <= ST_OK;
            set_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        row_q     <= req_row;
                        col_q     <= req_col;
                        target_q  <= req_weight;
                        pulse_cnt <= '0;
                        status_q  <= addr_ok ? ST_OK : ST_ADDR_ERR;
                    end
                end
                S_READ: begin
                    tmo_cnt <= '0;
                end
                S_WAIT_READ: begin
                    if (read_valid) begin
                        level_q <= read_level;
                    end else if (tmo_cnt == TMO_LAST) begin
                        status_q <= ST_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_COMPARE: begin
                    if (in_tol) begin
                        status_q <= ST_OK;
                    end else if (budget_spent) begin
                        status_q <= ST_FAIL;
                    end else begin
                        set_q   <= (level_q < target_q);
                        pcy_cnt <= '0;
                    end
                end
                S_PULSE: begin
                    if (pcy_cnt == PCY_LAST) begin
                        pcy_cnt <= '0;
                        if (!budget_spent) begin
                            pulse_cnt <= pulse_cnt + CNT_W'(1);
                        end
                    end else begin
                        pcy_cnt <= pcy_cnt + PCY_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlc_program_verify_ctrl.sv
// tb/tb_mlc_program_verify_ctrl.sv - randomized self-checking bench for mlc_program_verify_ctrl
//
// A behavioural cell model answers read strobes after a chosen latency and moves its level
// by one step per pulse. An iterative reference computes the expected status, pulse count,
// final level and response latency for each request.
module tb_mlc_program_verify_ctrl;

    localparam int PC   = 2;
    localparam int MAXP = 8;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_row;
    logic [3:0] req_col;
    logic [3:0] req_weight;
    logic [4:0] cell_row;
    logic [3:0] cell_col;
    logic       read_en;
    logic       read_valid;
    logic [3:0] read_level;
    logic       pulse_en;
    logic       pulse_set;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_status;
    logic [3:0] rsp_pulses;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // cell model state
    int cell_level = 0;
    int tgt_lvl    = 0;
    int rd_lat     = 1;
    bit no_resp    = 1'b0;
    bit stray      = 1'b0;
    int cd         = 0;
    int rd_cnt     = 0;
    int pe_cyc     = 0;
    int pulse_ev   = 0;
    int run_len    = 0;
    bit prev_pe    = 1'b0;
    bit run_set    = 1'b0;

    always #5 clk = ~clk;

    mlc_program_verify_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_row    (req_row),
        .req_col    (req_col),
        .req_weight (req_weight),
        .cell_row   (cell_row),
        .cell_col   (cell_col),
        .read_en    (read_en),
        .read_valid (read_valid),
        .read_level (read_level),
        .pulse_en   (pulse_en),
        .pulse_set  (pulse_set),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_pulses (rsp_pulses),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cell model and interface monitor, evaluated once per cycle away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                cd         = 0;
                read_valid = 1'b0;
                prev_pe    = 1'b0;
                run_len    = 0;
            end else begin
                if (read_en && pulse_en) chk("read_pulse_overlap", 32'(1), 32'(0));
                if (pulse_en) begin
                    if (!prev_pe) begin
                        pulse_ev++;
                        run_len = 0;
                        run_set = pulse_set;
                        chk("pulse_dir", 32'(pulse_set), 32'(cell_level < tgt_lvl));
                        if (pulse_set) cell_level = (cell_level < 15) ? cell_level + 1 : 15;
                        else           cell_level = (cell_level > 0)  ? cell_level - 1 : 0;
                    end else begin
                        chk("pulse_set_stable", 32'(pulse_set), 32'(run_set));
                    end
                    run_len++;
                    pe_cyc++;
                end else if (prev_pe) begin
                    chk("pulse_len", run_len, PC);
                end
                prev_pe = pulse_en;

                read_valid = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        read_valid = 1'b1;
                        read_level = 4'(cell_level);
                    end
                end
                if (read_en) begin
                    rd_cnt++;
                    if (!no_resp) cd = rd_lat;
                end
                // Junk responses while idle or pulsing must be ignored by the controller.
                if (stray && cd == 0 && !read_valid && (pulse_en || req_ready)) begin
                    read_valid = 1'b1;
                    read_level = 4'($urandom);
                end
            end
        end
    end

    // Issue one request and check everything about its outcome.
    task automatic do_req(input int row, input int col, input int w, input int lvl,
                          input int lat, input bit nr, input bit st);
        int exp_st, exp_np, exp_lvl, exp_rd, exp_cyc, cyc, hold, l, n;
        l = lvl;
        n = 0;
        if (row >= 32 || col >= 10) begin
            exp_st = 3; exp_rd = 0; exp_cyc = 1;
        end else if (nr) begin
            exp_st = 2; exp_rd = 1; exp_cyc = 2 + TMO;
        end else begin
            exp_st = 0;
            forever begin
                if (l == w) begin exp_st = 0; break; end
                if (n == MAXP) begin exp_st = 1; break; end
                l = (l < w) ? l + 1 : l - 1;
                n++;
            end
            exp_rd  = n + 1;
            exp_cyc = 3 + lat + n * (PC + 2 + lat);
        end
        exp_np  = n;
        exp_lvl = l;

        @(negedge clk);
        cell_level = lvl;
        tgt_lvl    = w;
        rd_lat     = lat;
        no_resp    = nr;
        stray      = st;
        rd_cnt     = 0;
        pe_cyc     = 0;
        pulse_ev   = 0;
        chk("req_ready_idle", 32'(req_ready), 32'(1));
        req_row    = 5'(row);
        req_col    = 4'(col);
        req_weight = 4'(w);
        req_valid  = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (rsp_valid || cyc > 2000) break;
        end
        chk("latency", cyc, exp_cyc);
        chk("status", 32'(rsp_status), exp_st);
        chk("pulses", 32'(rsp_pulses), exp_np);
        chk("cell_row", 32'(cell_row), row);
        chk("cell_col", 32'(cell_col), col);
        chk("read_count", rd_cnt, exp_rd);
        chk("pulse_count", pulse_ev, exp_np);
        chk("pulse_cycles", pe_cyc, exp_np * PC);
        chk("final_level", cell_level, exp_lvl);

        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_hold_valid", 32'(rsp_valid), 32'(1));
            chk("rsp_hold_status", 32'(rsp_status), exp_st);
            chk("rsp_hold_pulses", 32'(rsp_pulses), exp_np);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        stray     = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'(0));
        chk("back_idle", 32'(req_ready), 32'(1));
    endtask

    initial begin
        int waited;
        bit saw_rsp;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_row    = '0;
        req_col    = '0;
        req_weight = '0;
        read_valid = 1'b0;
        read_level = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_read_en", 32'(read_en), 32'(0));
        chk("rst_pulse_en", 32'(pulse_en), 32'(0));
        chk("rst_cell_row", 32'(cell_row), 32'(0));
        chk("rst_rsp_pulses", 32'(rsp_pulses), 32'(0));

        do_req(3, 2, 5, 5, 1, 1'b0, 1'b0);    // already at target
        do_req(7, 4, 6, 2, 1, 1'b0, 1'b0);    // four SET pulses
        do_req(0, 0, 0, 15, 1, 1'b0, 1'b0);   // budget exhausted
        do_req(31, 10, 4, 4, 1, 1'b0, 1'b0);  // column out of range
        do_req(31, 9, 4, 6, 1, 1'b0, 1'b0);   // follow-up completes
        do_req(1, 1, 3, 3, 1, 1'b1, 1'b1);    // no read response, stray pulses
        do_req(5, 5, 9, 6, 2, 1'b0, 1'b1);    // stray pulses during pulsing

        // Reset during the second pulse of a four-pulse job.
        @(negedge clk);
        cell_level = 2;
        tgt_lvl    = 6;
        rd_lat     = 1;
        no_resp    = 1'b0;
        pulse_ev   = 0;
        req_row    = 5'd2;
        req_col    = 4'd3;
        req_weight = 4'd6;
        req_valid  = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            req_valid = 1'b0;
            waited++;
            if (pulse_ev >= 2 || waited > 200) break;
        end
        chk("pre_rst_pulse_en", 32'(pulse_en), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pulse_en", 32'(pulse_en), 32'(0));
        chk("mid_rst_read_en", 32'(read_en), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_req_ready", 32'(req_ready), 32'(1));
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        saw_rsp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_rsp = saw_rsp | rsp_valid | busy;
        end
        chk("post_rst_quiet", 32'(saw_rsp), 32'(0));
        do_req(2, 3, 6, 2, 1, 1'b0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            do_req($urandom_range(0, 31), $urandom_range(0, 12), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(1, 3), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
